// File: rtl/pzcorebus_sram_responder.sv
// Terminal pzcorebus slave: flop-array scratch memory serving one command at a time.
// Reads return one beat per accepted response; writes ack once (posted writes never ack).
module pzcorebus_sram_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 8,
  parameter int LENGTH_WIDTH  = 8,
  parameter int WORDS         = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mcmd_valid,
  output logic                      o_scmd_accept,
  input  logic [1:0]                i_mcmd,
  input  logic [ID_WIDTH-1:0]       i_mid,
  input  logic [ADDRESS_WIDTH-1:0]  i_maddress,
  input  logic [LENGTH_WIDTH-1:0]   i_mlength,
  input  logic                      i_mdata_valid,
  output logic                      o_sdata_accept,
  input  logic [DATA_WIDTH-1:0]     i_mdata,
  input  logic [DATA_WIDTH/8-1:0]   i_mdata_byteen,
  input  logic                      i_mdata_last,
  output logic                      o_sresp_valid,
  input  logic                      i_mresp_accept,
  output logic                      o_sresp,
  output logic [ID_WIDTH-1:0]       o_sid,
  output logic                      o_serror,
  output logic [DATA_WIDTH-1:0]     o_sdata,
  output logic                      o_sresp_last
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = LENGTH_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                error_q, error_d;
  logic                posted_q, posted_d;

  logic                  out_of_range;
  logic [CNT_W-1:0]      cmd_len;
  logic                  last_beat;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  // Any address bit above the memory window makes the whole command an error.
  generate
    if (ADDRESS_WIDTH > OFF + IDX_W) begin : g_range
      assign out_of_range = |i_maddress[ADDRESS_WIDTH-1:OFF+IDX_W];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
    if (OFF > 0) begin : g_offset
      logic unused_offset_bits;
      assign unused_offset_bits = ^i_maddress[OFF-1:0];
    end
  endgenerate

  assign cmd_len   = (i_mlength == '0) ? {1'b1, {LENGTH_WIDTH{1'b0}}} : {1'b0, i_mlength};
  assign last_beat = (remaining_q == CNT_W'(1));

  // One flop array per byte lane so byte enables map onto independent writes.
  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] lane_q [WORDS];
      always_ff @(posedge i_clk) begin
        if (mem_we && i_mdata_byteen[gi]) begin
          lane_q[idx_q] <= i_mdata[gi*8 +: 8];
        end
      end
      assign rd_data[gi*8 +: 8] = lane_q[idx_q];
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    idx_d          = idx_q;
    remaining_d    = remaining_q;
    error_d        = error_q;
    posted_d       = posted_q;
    mem_we         = 1'b0;
    o_scmd_accept  = 1'b0;
    o_sdata_accept = 1'b0;
    o_sresp_valid  = 1'b0;
    o_sresp        = 1'b0;
    o_sid          = '0;
    o_serror       = 1'b0;
    o_sdata        = '0;
    o_sresp_last   = 1'b0;
    if (!i_rst) begin
      case (state_q)
        IDLE: begin
          o_scmd_accept = 1'b1;
          if (i_mcmd_valid) begin
            id_d        = i_mid;
            idx_d       = i_maddress[OFF +: IDX_W];
            remaining_d = cmd_len;
            error_d     = out_of_range;
            posted_d    = (i_mcmd == 2'd2);
            case (i_mcmd)
              2'd0:       state_d = RDATA;
              2'd1, 2'd2: state_d = WDATA;
              default: begin
                error_d     = 1'b1;
                remaining_d = CNT_W'(1);
                state_d     = RDATA;
              end
            endcase
          end
        end
        WDATA: begin
          o_sdata_accept = 1'b1;
          if (i_mdata_valid) begin
            mem_we      = !error_q;
            idx_d       = idx_q + IDX_W'(1);
            remaining_d = remaining_q - CNT_W'(1);
            // The burst length is fixed by the command; a misplaced last marker only flags an error.
            if (i_mdata_last != last_beat) begin
              error_d = 1'b1;
            end
            if (last_beat) begin
              state_d = posted_q ? IDLE : WRESP;
            end
          end
        end
        WRESP: begin
          o_sresp_valid = 1'b1;
          o_sresp_last  = 1'b1;
          o_sid         = id_q;
          o_serror      = error_q;
          if (i_mresp_accept) begin
            state_d = IDLE;
          end
        end
        RDATA: begin
          o_sresp_valid = 1'b1;
          o_sresp       = 1'b1;
          o_sid         = id_q;
          o_serror      = error_q;
          o_sdata       = error_q ? '0 : rd_data;
          o_sresp_last  = last_beat;
          if (i_mresp_accept) begin
            idx_d       = idx_q + IDX_W'(1);
            remaining_d = remaining_q - CNT_W'(1);
            if (last_beat) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      idx_q       <= '0;
      remaining_q <= '0;
      error_q     <= 1'b0;
      posted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      error_q     <= error_d;
      posted_q    <= posted_d;
    end
  end

endmodule

// File: tb/tb_pzcorebus_sram_responder.sv
// Randomized self-checking bench for pzcorebus_sram_responder against a word-array model.
module tb_pzcorebus_sram_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int LW = 8;
  localparam int WORDS = 256;

  logic          i_clk, i_rst;
  logic          i_mcmd_valid, o_scmd_accept;
  logic [1:0]    i_mcmd;
  logic [IW-1:0] i_mid;
  logic [AW-1:0] i_maddress;
  logic [LW-1:0] i_mlength;
  logic          i_mdata_valid, o_sdata_accept;
  logic [DW-1:0] i_mdata;
  logic [3:0]    i_mdata_byteen;
  logic          i_mdata_last;
  logic          o_sresp_valid, i_mresp_accept, o_sresp;
  logic [IW-1:0] o_sid;
  logic          o_serror;
  logic [DW-1:0] o_sdata;
  logic          o_sresp_last;

  pzcorebus_sram_responder #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LENGTH_WIDTH(LW), .WORDS(WORDS)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_mcmd_valid(i_mcmd_valid), .o_scmd_accept(o_scmd_accept), .i_mcmd(i_mcmd),
    .i_mid(i_mid), .i_maddress(i_maddress), .i_mlength(i_mlength),
    .i_mdata_valid(i_mdata_valid), .o_sdata_accept(o_sdata_accept), .i_mdata(i_mdata),
    .i_mdata_byteen(i_mdata_byteen), .i_mdata_last(i_mdata_last),
    .o_sresp_valid(o_sresp_valid), .i_mresp_accept(i_mresp_accept), .o_sresp(o_sresp),
    .o_sid(o_sid), .o_serror(o_serror), .o_sdata(o_sdata), .o_sresp_last(o_sresp_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [WORDS];
  logic [31:0] wbuf [256];
  logic [3:0]  wbe  [256];
  logic        wlast[256];
  logic [31:0] r_data [256];
  logic        r_resp [256];
  logic [7:0]  r_id   [256];
  logic        r_err  [256];
  logic        r_last [256];
  int          r_first_wait;

  function automatic int word_of(input logic [31:0] addr, input int beat);
    return int'(((addr / 4) + beat) % WORDS);
  endfunction

  function automatic void model_write(input int w, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) model_mem[w][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  task automatic do_cmd(input logic [1:0] c, input logic [7:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
    int t = 0;
    $display("txn cmd=%0d id=%h addr=%h len=%0d", c, id, addr, len);
    i_mcmd_valid = 1'b1; i_mcmd = c; i_mid = id; i_maddress = addr; i_mlength = len;
    while (o_scmd_accept !== 1'b1 && t < 50) begin
      @(posedge i_clk); #1; t++;
    end
    n_assert++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL cmd_accept_timeout: scmd_accept=%b required 1", o_scmd_accept);
    end
    @(posedge i_clk); #1;
    i_mcmd_valid = 1'b0;
  endtask

  task automatic do_wdata(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      i_mdata_valid = 1'b1; i_mdata = wbuf[i]; i_mdata_byteen = wbe[i]; i_mdata_last = wlast[i];
      while (o_sdata_accept !== 1'b1 && t < 50) begin
        @(posedge i_clk); #1; t++;
      end
      n_assert++;
      if (t >= 50) begin
        n_fail++;
        $display("FAIL wdata_timeout beat %0d: sdata_accept=%b required 1", i, o_sdata_accept);
      end
      @(posedge i_clk); #1;
    end
    i_mdata_valid = 1'b0; i_mdata_last = 1'b0;
  endtask

  task automatic get_resp(input int n, input bit rand_bp);
    r_first_wait = -1;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bit done = 1'b0;
      while (!done && t < 100) begin
        if (o_sresp_valid === 1'b1 && (!rand_bp || $urandom_range(0, 2) != 0)) begin
          if (i == 0) r_first_wait = t;
          r_data[i] = o_sdata; r_resp[i] = o_sresp; r_id[i] = o_sid;
          r_err[i] = o_serror; r_last[i] = o_sresp_last;
          i_mresp_accept = 1'b1;
          @(posedge i_clk); #1;
          i_mresp_accept = 1'b0;
          done = 1'b1;
        end else begin
          i_mresp_accept = 1'b0;
          @(posedge i_clk); #1; t++;
        end
      end
      n_assert++;
      if (!done) begin
        n_fail++;
        $display("FAIL resp_timeout beat %0d: sresp_valid=%b required 1", i, o_sresp_valid);
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_mcmd_valid = 1'b1; i_mcmd = 2'd0; i_maddress = '0; i_mlength = 8'd1;
    repeat (3) begin
      @(posedge i_clk); #1;
      n_assert++;
      if ({o_scmd_accept, o_sdata_accept, o_sresp_valid, o_sresp, o_sid, o_serror, o_sdata,
           o_sresp_last} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: accept=%b sresp_valid=%b sdata=%h required all 0",
                 o_scmd_accept, o_sresp_valid, o_sdata);
      end
    end
    i_rst = 1'b0; i_mcmd_valid = 1'b0;
    @(posedge i_clk); #1;
    n_assert++;
    if (o_scmd_accept !== 1'b1 || o_sresp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: scmd_accept=%b sresp_valid=%b required 1/0",
               o_scmd_accept, o_sresp_valid);
    end
  endtask

  // Length 0 encodes 256 beats: fills the whole memory so the model is fully known.
  task automatic test_fill();
    for (int i = 0; i < 256; i++) begin
      wbuf[i] = $urandom; wbe[i] = 4'hF; wlast[i] = (i == 255);
    end
    do_cmd(2'd1, 8'h01, 32'h0, 8'd0);
    do_wdata(256);
    for (int i = 0; i < 256; i++) model_write(word_of(32'h0, i), wbuf[i], wbe[i]);
    get_resp(1, 1'b0);
    n_assert++;
    if (r_first_wait !== 0 || r_resp[0] !== 1'b0 || r_id[0] !== 8'h01 || r_err[0] !== 1'b0 ||
        r_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_resp: wait=%0d sresp=%b sid=%h err=%b last=%b required 0/0/01/0/1",
               r_first_wait, r_resp[0], r_id[0], r_err[0], r_last[0]);
    end
    n_assert++;
    if (o_sresp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_single_resp: sresp_valid=%b required 0", o_sresp_valid);
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hA0 + i; wbe[i] = 4'hF; wlast[i] = (i == 3);
    end
    do_cmd(2'd1, 8'h12, 32'h10, 8'd4);
    do_wdata(4);
    for (int i = 0; i < 4; i++) model_write(word_of(32'h10, i), wbuf[i], wbe[i]);
    get_resp(1, 1'b0);
    n_assert++;
    if (r_first_wait !== 0 || r_resp[0] !== 1'b0 || r_id[0] !== 8'h12 || r_err[0] !== 1'b0 ||
        r_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL write_resp: wait=%0d sresp=%b sid=%h err=%b last=%b required 0/0/12/0/1",
               r_first_wait, r_resp[0], r_id[0], r_err[0], r_last[0]);
    end
    do_cmd(2'd0, 8'h13, 32'h10, 8'd4);
    get_resp(4, 1'b0);
    n_assert++;
    if (r_first_wait !== 0) begin
      n_fail++;
      $display("FAIL read_latency: wait=%0d required 0", r_first_wait);
    end
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      if (r_data[i] !== 32'hA0 + i || r_data[i] !== model_mem[word_of(32'h10, i)] ||
          r_last[i] !== (i == 3) || r_resp[i] !== 1'b1 || r_id[i] !== 8'h13 || r_err[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL read_beat %0d: data=%h last=%b sresp=%b sid=%h err=%b required %h/%b/1/13/0",
                 i, r_data[i], r_last[i], r_resp[i], r_id[i], r_err[i], 32'hA0 + i, (i == 3));
      end
    end
  endtask

  task automatic test_wrap_byteen();
    wbuf[0] = 32'h11223344; wbuf[1] = 32'h55667788;
    wbe[0] = 4'h3; wbe[1] = 4'h3; wlast[0] = 1'b0; wlast[1] = 1'b1;
    do_cmd(2'd2, 8'h20, 32'h3FC, 8'd2);
    do_wdata(2);
    for (int i = 0; i < 2; i++) model_write(word_of(32'h3FC, i), wbuf[i], wbe[i]);
    @(posedge i_clk); #1;
    n_assert++;
    if (o_sresp_valid !== 1'b0 || o_scmd_accept !== 1'b1) begin
      n_fail++;
      $display("FAIL posted_no_resp: sresp_valid=%b scmd_accept=%b required 0/1",
               o_sresp_valid, o_scmd_accept);
    end
    do_cmd(2'd0, 8'h21, 32'h3FC, 8'd2);
    get_resp(2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_assert++;
      if (r_data[i] !== model_mem[word_of(32'h3FC, i)] ||
          r_data[i][15:0] !== (i == 0 ? 16'h3344 : 16'h7788) || r_last[i] !== (i == 1)) begin
        n_fail++;
        $display("FAIL wrap_read %0d: data=%h last=%b required %h/%b",
                 i, r_data[i], r_last[i], model_mem[word_of(32'h3FC, i)], (i == 1));
      end
    end
  endtask

  task automatic test_backpressure();
    logic pat [6];
    int beat = 0;
    pat[0] = 1'b0; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1; pat[5] = 1'b1;
    do_cmd(2'd0, 8'h33, 32'h40, 8'd3);
    for (int k = 0; k < 6; k++) begin
      n_assert++;
      if (o_sresp_valid !== 1'b1 || o_sdata !== model_mem[word_of(32'h40, beat)] ||
          o_sresp_last !== (beat == 2) || o_sid !== 8'h33) begin
        n_fail++;
        $display("FAIL bp_cycle %0d: valid=%b data=%h last=%b sid=%h required 1/%h/%b/33",
                 k, o_sresp_valid, o_sdata, o_sresp_last, o_sid,
                 model_mem[word_of(32'h40, beat)], (beat == 2));
      end
      i_mresp_accept = pat[k];
      if (pat[k] && o_sresp_valid === 1'b1) beat++;
      @(posedge i_clk); #1;
    end
    i_mresp_accept = 1'b0;
    n_assert++;
    if (beat != 3 || o_sresp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_count: beats=%0d valid=%b required 3/0", beat, o_sresp_valid);
    end
  endtask

  task automatic test_errors();
    do_cmd(2'd0, 8'h44, 32'h400, 8'd2);
    get_resp(2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_assert++;
      if (r_err[i] !== 1'b1 || r_data[i] !== 32'h0 || r_last[i] !== (i == 1) || r_id[i] !== 8'h44) begin
        n_fail++;
        $display("FAIL oor_read %0d: err=%b data=%h last=%b sid=%h required 1/0/%b/44",
                 i, r_err[i], r_data[i], r_last[i], r_id[i], (i == 1));
      end
    end
    wbuf[0] = 32'hDEADBEEF; wbe[0] = 4'hF; wlast[0] = 1'b1;
    do_cmd(2'd1, 8'h45, 32'h400, 8'd1);
    do_wdata(1);
    get_resp(1, 1'b0);
    n_assert++;
    if (r_err[0] !== 1'b1 || r_resp[0] !== 1'b0 || r_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_write_resp: err=%b sresp=%b last=%b required 1/0/1",
               r_err[0], r_resp[0], r_last[0]);
    end
    do_cmd(2'd0, 8'h46, 32'h0, 8'd1);
    get_resp(1, 1'b0);
    n_assert++;
    if (r_data[0] !== model_mem[0] || r_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_write_nomod: data=%h err=%b required %h/0", r_data[0], r_err[0], model_mem[0]);
    end
    do_cmd(2'd3, 8'h55, 32'h20, 8'd5);
    get_resp(1, 1'b0);
    n_assert++;
    if (r_err[0] !== 1'b1 || r_last[0] !== 1'b1 || r_resp[0] !== 1'b1 || r_data[0] !== 32'h0 ||
        r_id[0] !== 8'h55 || o_sresp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reserved_cmd: err=%b last=%b sresp=%b data=%h sid=%h valid_after=%b required 1/1/1/0/55/0",
               r_err[0], r_last[0], r_resp[0], r_data[0], r_id[0], o_sresp_valid);
    end
  endtask

  task automatic test_last_mismatch();
    do_cmd(2'd1, 8'h66, 32'h80, 8'd2);
    wbuf[0] = 32'h01010101; wbe[0] = 4'hF; wlast[0] = 1'b1;
    do_wdata(1);
    n_assert++;
    if (o_sdata_accept !== 1'b1 || o_sresp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_continue: sdata_accept=%b sresp_valid=%b required 1/0",
               o_sdata_accept, o_sresp_valid);
    end
    wbuf[0] = 32'h02020202;
    do_wdata(1);
    get_resp(1, 1'b0);
    n_assert++;
    if (r_err[0] !== 1'b1 || r_id[0] !== 8'h66 || r_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch_resp: err=%b sid=%h last=%b required 1/66/1", r_err[0], r_id[0], r_last[0]);
    end
    for (int i = 0; i < 2; i++) begin
      wbuf[i] = $urandom; wbe[i] = 4'hF; wlast[i] = (i == 1);
    end
    do_cmd(2'd1, 8'h67, 32'h80, 8'd2);
    do_wdata(2);
    for (int i = 0; i < 2; i++) model_write(word_of(32'h80, i), wbuf[i], wbe[i]);
    get_resp(1, 1'b0);
    n_assert++;
    if (r_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rewrite_resp: err=%b required 0", r_err[0]);
    end
  endtask

  task automatic test_reset_midburst();
    do_cmd(2'd0, 8'h77, 32'h100, 8'd4);
    get_resp(1, 1'b0);
    n_assert++;
    if (o_sresp_valid !== 1'b1 || o_sdata !== model_mem[word_of(32'h100, 1)]) begin
      n_fail++;
      $display("FAIL midburst_beat2: valid=%b data=%h required 1/%h",
               o_sresp_valid, o_sdata, model_mem[word_of(32'h100, 1)]);
    end
    i_rst = 1'b1;
    #1;
    n_assert++;
    if ({o_scmd_accept, o_sdata_accept, o_sresp_valid, o_sid, o_serror, o_sdata, o_sresp_last} !== '0) begin
      n_fail++;
      $display("FAIL midburst_rst_outputs: valid=%b data=%h sid=%h required all 0", o_sresp_valid, o_sdata, o_sid);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    n_assert++;
    if (o_sresp_valid !== 1'b0 || o_scmd_accept !== 1'b1) begin
      n_fail++;
      $display("FAIL midburst_idle: sresp_valid=%b scmd_accept=%b required 0/1", o_sresp_valid, o_scmd_accept);
    end
    @(posedge i_clk); #1;
    n_assert++;
    if (o_sresp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midburst_abandoned: sresp_valid=%b required 0", o_sresp_valid);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      logic [1:0]  c;
      logic [31:0] addr;
      logic [7:0]  id;
      int          len;
      c    = 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 1023));
      id   = 8'($urandom);
      len  = int'($urandom_range(1, 6));
      if (c == 2'd0) begin
        do_cmd(c, id, addr, 8'(len));
        get_resp(len, 1'b1);
        for (int i = 0; i < len; i++) begin
          n_assert++;
          if (r_data[i] !== model_mem[word_of(addr, i)] || r_last[i] !== (i == len - 1) ||
              r_id[i] !== id || r_err[i] !== 1'b0 || r_resp[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_read it%0d beat%0d: data=%h last=%b sid=%h err=%b required %h/%b/%h/0",
                     it, i, r_data[i], r_last[i], r_id[i], r_err[i],
                     model_mem[word_of(addr, i)], (i == len - 1), id);
          end
        end
      end else begin
        for (int i = 0; i < len; i++) begin
          wbuf[i] = $urandom; wbe[i] = 4'($urandom); wlast[i] = (i == len - 1);
        end
        do_cmd(c, id, addr, 8'(len));
        do_wdata(len);
        for (int i = 0; i < len; i++) model_write(word_of(addr, i), wbuf[i], wbe[i]);
        if (c == 2'd1) begin
          get_resp(1, 1'b1);
          n_assert++;
          if (r_resp[0] !== 1'b0 || r_id[0] !== id || r_err[0] !== 1'b0 || r_last[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_write it%0d: sresp=%b sid=%h err=%b last=%b required 0/%h/0/1",
                     it, r_resp[0], r_id[0], r_err[0], r_last[0], id);
          end
        end
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_mcmd_valid = 1'b0; i_mcmd = '0; i_mid = '0; i_maddress = '0; i_mlength = '0;
    i_mdata_valid = 1'b0; i_mdata = '0; i_mdata_byteen = '0; i_mdata_last = 1'b0;
    i_mresp_accept = 1'b0;
    test_reset();
    test_fill();
    test_write_read();
    test_wrap_byteen();
    test_backpressure();
    test_errors();
    test_last_mismatch();
    test_reset_midburst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
